uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// UART receiver with programmable divisor, optional parity and a receive FIFO
// behind a 4-register bus slave with one-cycle registered read latency.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_RESET  = 434
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic        chipselect,
  input  logic [31:0] writedata,
  input  logic        RX_in,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = DATA_BITS + 2;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

  logic        rd_en, wr_en;
  logic [3:0]  ctrl;
  logic [15:0] divisor;
  logic        ovr;
  logic        en, par_en, par_odd, ie;

  assign rd_en   = chipselect & read;
  assign wr_en   = chipselect & write;
  assign en      = ctrl[0];
  assign par_en  = ctrl[1];
  assign par_odd = ctrl[2];
  assign ie      = ctrl[3];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl    <= 4'h1;
      divisor <= 16'(DIV_RESET);
    end else if (wr_en) begin
      case (address)
        2'd2: ctrl <= writedata[3:0];
        2'd3: divisor <= (writedata[15:0] < 16'd4) ? 16'd4 : writedata[15:0];
        default: ;
      endcase
    end
  end

  // Input synchronizer; rx_prev gives the previous synchronized level for edge detect
  logic rx_meta, rx_sync, rx_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX_in;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  rx_state_t             state_q, state_d;
  logic [15:0]           cnt_q, cnt_d, div_q, div_d;
  logic [3:0]            bit_q, bit_d;
  logic                  pe_q, pe_d;
  logic [DATA_BITS-1:0]  shreg_q;
  logic                  shift_en, push;
  logic                  tick_half, tick_full;
  logic [EW-1:0]         push_word;

  assign tick_half = (cnt_q == ((div_q >> 1) - 16'd1));
  assign tick_full = (cnt_q == (div_q - 16'd1));
  assign push_word = {~rx_sync, pe_q, shreg_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      div_q   <= 16'd4;
      bit_q   <= 4'd0;
      pe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      pe_q    <= pe_d;
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en) shreg_q <= {rx_sync, shreg_q[DATA_BITS-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 16'd1;
    div_d    = div_q;
    bit_d    = bit_q;
    pe_d     = pe_q;
    shift_en = 1'b0;
    push     = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = 16'd0;
          if (rx_prev && !rx_sync) begin
            state_d = START;
            div_d   = divisor;
            pe_d    = 1'b0;
          end
        end
        START: if (tick_half) begin
          cnt_d   = 16'd0;
          bit_d   = 4'd0;
          state_d = rx_sync ? IDLE : DATA;
        end
        DATA: if (tick_full) begin
          cnt_d    = 16'd0;
          shift_en = 1'b1;
          if (bit_q == 4'(DATA_BITS - 1)) state_d = par_en ? PARITY : STOP;
          else bit_d = bit_q + 4'd1;
        end
        PARITY: if (tick_full) begin
          cnt_d   = 16'd0;
          pe_d    = ((^shreg_q) ^ rx_sync) != par_odd;
          state_d = STOP;
        end
        STOP: if (tick_full) begin
          cnt_d   = 16'd0;
          push    = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Receive FIFO; a push while full is dropped unless a pop frees the slot on the same edge
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, pop, do_push, overrun;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign pop     = rd_en && (address == 2'd0) && !empty;
  assign do_push = push && (!full || pop);
  assign overrun = push && full && !pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovr    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (overrun) ovr <= 1'b1;
      else if (wr_en && (address == 2'd1) && writedata[2]) ovr <= 1'b0;
    end
  end

  logic [EW-1:0] head;
  logic [31:0]   count_ext, data_word, status_word, rd_mux;
  logic [7:0]    occ;

  assign head        = mem[rd_ptr];
  assign count_ext   = 32'(count);
  assign occ         = (count_ext > 32'd255) ? 8'hFF : count_ext[7:0];
  assign data_word   = empty ? 32'd0
                     : {1'b1, 20'd0, head[EW-1], head[EW-2], 9'(head[DATA_BITS-1:0])};
  assign status_word = {16'd0, occ, 5'd0, ovr, full, ~empty};

  always_comb begin
    rd_mux = 32'd0;
    case (address)
      2'd0: rd_mux = data_word;
      2'd1: rd_mux = status_word;
      2'd2: rd_mux = {28'd0, ctrl};
      2'd3: rd_mux = {16'd0, divisor};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= 32'd0;
    else if (rd_en) readdata <= rd_mux;
  end

  assign irq = (~empty & ie) | ovr;

  logic unused_bits;
  assign unused_bits = &{1'b0, writedata[31:16]};

endmodule
